// File: rtl/pipelined_add_sub_pkg.sv
// Shared types and the one-bit full-adder cell used by the pipelined adder/subtractor.
package pipelined_add_sub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_e;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } addsub_flags_t;

    // Returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/pipelined_add_sub_slice.sv
// Combinational CHUNK-bit add/sub slice: a ripple chain of full-adder cells.
module add_sub_slice
    import pipelined_add_sub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             invert_b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            {c[i+1], sum[i]} = full_add(a[i], b[i] ^ invert_b, c[i]);
        end
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit carry slice per stage, valid/ready
// on both sides, flags produced alongside the final result.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int CHUNK = WIDTH / STAGES;

    function automatic addsub_flags_t calc_flags(input logic [WIDTH-1:0] res,
                                                 input logic c_out,
                                                 input logic c_msb_in);
        addsub_flags_t f;
        f.c = c_out;
        f.v = c_msb_in ^ c_out;
        f.z = (res == '0);
        f.n = res[WIDTH-1];
        return f;
    endfunction

    // The whole pipe moves together; a full output register blocks everything.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC_W = WIDTH - k * CHUNK;
        localparam int RES_W = (k + 1) * CHUNK;

        logic [SRC_W-1:0] a_in;
        logic [SRC_W-1:0] b_in;
        logic             op_in;
        logic             cin_in;
        logic             vld_d;
        logic             vld_q;
        logic [RES_W-1:0] res_d;
        logic [CHUNK-1:0] sum;
        logic             cout;
        logic             c_msb_in;

        add_sub_slice #(.CHUNK(CHUNK)) u_slice (
            .a        (a_in[CHUNK-1:0]),
            .b        (b_in[CHUNK-1:0]),
            .invert_b (op_in),
            .cin      (cin_in),
            .sum      (sum),
            .cout     (cout),
            .c_msb_in (c_msb_in)
        );

        if (k == 0) begin : g_head
            always_comb begin
                a_in   = in_a;
                b_in   = in_b;
                op_in  = in_op;
                cin_in = (in_op == OP_SUB) ? 1'b1 : in_cin;
                vld_d  = in_valid;
                res_d  = sum;
            end
        end else begin : g_tail
            always_comb begin
                a_in   = g_stage[k-1].g_mid.a_q;
                b_in   = g_stage[k-1].g_mid.b_q;
                op_in  = g_stage[k-1].g_mid.op_q;
                cin_in = g_stage[k-1].g_mid.carry_q;
                vld_d  = g_stage[k-1].vld_q;
                res_d  = {sum, g_stage[k-1].g_mid.res_q};
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (advance) begin
                vld_q <= vld_d;
            end
        end

        // ---- stage k -> k+1 boundary: resolved low chunks, still-pending high operand chunks
        if (k < STAGES - 1) begin : g_mid
            localparam int PEND_W = SRC_W - CHUNK;

            logic [PEND_W-1:0] a_d, b_d, a_q, b_q;
            logic [RES_W-1:0]  res_q;
            logic              op_d, op_q, carry_d, carry_q;

            always_comb begin
                a_d     = a_in[SRC_W-1:CHUNK];
                b_d     = b_in[SRC_W-1:CHUNK];
                op_d    = op_in;
                carry_d = cout;
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    op_q    <= op_d;
                    carry_q <= carry_d;
                    res_q   <= res_d;
                end
            end
        end else begin : g_last
            // ---- output register: full result and flags
            logic [WIDTH-1:0] res_q;
            addsub_flags_t    flags_d, flags_q;

            always_comb begin
                flags_d = calc_flags(res_d, cout, c_msb_in);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    res_q   <= '0;
                    flags_q <= '0;
                end else if (advance) begin
                    res_q   <= res_d;
                    flags_q <= flags_d;
                end
            end
        end
    end

    assign out_valid  = g_stage[STAGES-1].vld_q;
    assign out_result = g_stage[STAGES-1].g_last.res_q;
    assign out_carry  = g_stage[STAGES-1].g_last.flags_q.c;
    assign out_ovf    = g_stage[STAGES-1].g_last.flags_q.v;
    assign out_zero   = g_stage[STAGES-1].g_last.flags_q.z;
    assign out_neg    = g_stage[STAGES-1].g_last.flags_q.n;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: four instances (32b/4, 32b/1, 32b/8 stages, 4b/2 stages)
// checked against a plain-arithmetic reference model and a result queue.
module tb_pipelined_add_sub;

    typedef struct {
        logic [31:0] r;
        logic        c, v, z, n;
    } exp_t;

    logic clk, rst;
    logic [3:0]        iv, iop, icin, ordy;
    logic [3:0][31:0]  ia, ib;
    logic [3:0]        ov, ir, oc, oo, oz, on;
    logic [3:0][31:0]  ores;

    int errors = 0;
    int checks = 0;
    int lat[4] = '{4, 1, 8, 2};
    int wid[4] = '{32, 32, 32, 4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
        .in_op(iop[0]), .in_cin(icin[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_result(ores[0]), .out_carry(oc[0]), .out_ovf(oo[0]), .out_zero(oz[0]), .out_neg(on[0]));

    pipelined_add_sub #(.WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
        .in_op(iop[1]), .in_cin(icin[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_result(ores[1]), .out_carry(oc[1]), .out_ovf(oo[1]), .out_zero(oz[1]), .out_neg(on[1]));

    pipelined_add_sub #(.WIDTH(32), .STAGES(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2]), .in_b(ib[2]),
        .in_op(iop[2]), .in_cin(icin[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_result(ores[2]), .out_carry(oc[2]), .out_ovf(oo[2]), .out_zero(oz[2]), .out_neg(on[2]));

    pipelined_add_sub #(.WIDTH(4), .STAGES(2)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_a(ia[3][3:0]), .in_b(ib[3][3:0]),
        .in_op(iop[3]), .in_cin(icin[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .out_result(ores[3][3:0]), .out_carry(oc[3]), .out_ovf(oo[3]), .out_zero(oz[3]), .out_neg(on[3]));
    assign ores[3][31:4] = '0;

    // Reference: A + (op ? ~B : B) + (op ? 1 : cin) in wide arithmetic, flags from sign rules.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic op, input logic cin, input int w);
        logic [63:0] mask, aa, bb, s;
        exp_t e;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = op ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        s    = aa + bb + (op ? 64'd1 : {63'd0, cin});
        e.r  = s[31:0] & mask[31:0];
        e.c  = s[w];
        e.n  = e.r[w-1];
        e.z  = (e.r == 32'd0);
        e.v  = (aa[w-1] == bb[w-1]) && (e.n != aa[w-1]);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", ov[0], ir[0]);
        end
        checks++;
        if (ores[0] !== 32'd0 || {oc[0], oo[0], oz[0], on[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: result=%h cvzn=%b%b%b%b, required 0/0000",
                     ores[0], oc[0], oo[0], oz[0], on[0]);
        end
    endtask

    task automatic test_directed(input int s);
        logic [31:0] va[4] = '{32'h5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3};
        logic [31:0] vb[4] = '{32'h3, 32'h1, 32'h1, 32'h5};
        logic        vop[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_t e;
        int cnt;
        @(posedge clk); #1;
        ordy[s] = 1'b1;
        for (int v = 0; v < 4; v++) begin
            iv[s] = 1'b1; ia[s] = va[v]; ib[s] = vb[v]; iop[s] = vop[v]; icin[s] = 1'b0;
            e = model(va[v], vb[v], vop[v], 1'b0, wid[s]);
            #1;
            checks++;
            if (ir[s] !== 1'b1) begin
                errors++;
                $display("FAIL dir_ready dut%0d vec%0d: in_ready=%b, required 1", s, v, ir[s]);
            end
            @(posedge clk); #1;
            iv[s] = 1'b0;
            #1;
            cnt = 1;
            while (ov[s] !== 1'b1 && cnt < 40) begin
                @(posedge clk); #2;
                cnt++;
            end
            checks++;
            if (cnt != lat[s]) begin
                errors++;
                $display("FAIL dir_latency dut%0d vec%0d: %0d cycles, required %0d", s, v, cnt, lat[s]);
            end
            checks++;
            if (ores[s] !== e.r || {oc[s], oo[s], oz[s], on[s]} !== {e.c, e.v, e.z, e.n}) begin
                errors++;
                $display("FAIL dir_value dut%0d vec%0d: result=%h cvzn=%b%b%b%b, required %h cvzn=%b%b%b%b",
                         s, v, ores[s], oc[s], oo[s], oz[s], on[s], e.r, e.c, e.v, e.z, e.n);
            end
        end
        @(posedge clk); #1;
    endtask

    // Back-to-back stream with out_ready=1; sweep=1 walks every 4-bit a/b/op/cin combination.
    task automatic test_back_to_back(input int s, input int n, input bit sweep);
        exp_t q[$];
        exp_t e;
        int sent, got, gap, cyc;
        logic [9:0] idx;
        sent = 0; got = 0; gap = 0; cyc = 0;
        @(posedge clk); #1;
        ordy[s] = 1'b1;
        while ((sent < n || q.size() > 0) && cyc < n + lat[s] + 20) begin
            if (sent < n) begin
                iv[s] = 1'b1;
                if (sweep) begin
                    idx = 10'(sent);
                    ia[s] = {28'd0, idx[3:0]}; ib[s] = {28'd0, idx[7:4]};
                    iop[s] = idx[8]; icin[s] = idx[9];
                end else begin
                    ia[s] = $urandom; ib[s] = $urandom;
                    iop[s] = 1'($urandom_range(0, 1)); icin[s] = 1'($urandom_range(0, 1));
                end
            end else begin
                iv[s] = 1'b0;
            end
            #1;
            if (ov[s] === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious dut%0d: unexpected result %h", s, ores[s]);
                end else begin
                    e = q.pop_front();
                    if (ores[s] !== e.r || {oc[s], oo[s], oz[s], on[s]} !== {e.c, e.v, e.z, e.n}) begin
                        errors++;
                        $display("FAIL b2b_value dut%0d beat%0d: result=%h cvzn=%b%b%b%b, required %h cvzn=%b%b%b%b",
                                 s, got, ores[s], oc[s], oo[s], oz[s], on[s], e.r, e.c, e.v, e.z, e.n);
                    end
                end
                got++;
            end else if (got > 0 && got < n) begin
                gap++;
            end
            if (iv[s] && ir[s]) begin
                q.push_back(model(ia[s], ib[s], iop[s], icin[s], wid[s]));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        iv[s] = 1'b0;
        checks++;
        if (got != n || sent != n) begin
            errors++;
            $display("FAIL b2b_count dut%0d: sent=%0d got=%0d, required %0d", s, sent, got, n);
        end
        checks++;
        if (gap != 0) begin
            errors++;
            $display("FAIL b2b_throughput dut%0d: %0d idle cycles mid-stream, required 0", s, gap);
        end
    endtask

    task automatic test_backpressure(input int s);
        exp_t q[$];
        exp_t e;
        int cyc;
        logic [31:0] snap_r;
        logic [3:0]  snap_f;
        cyc = 0;
        @(posedge clk); #1;
        ordy[s] = 1'b0;
        while (cyc < 30) begin
            iv[s] = 1'b1; ia[s] = $urandom; ib[s] = $urandom;
            iop[s] = 1'($urandom_range(0, 1)); icin[s] = 1'($urandom_range(0, 1));
            #1;
            if (ir[s] !== 1'b1) break;
            q.push_back(model(ia[s], ib[s], iop[s], icin[s], wid[s]));
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (q.size() != lat[s] || ov[s] !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill dut%0d: accepted=%0d out_valid=%b, required %0d/1", s, q.size(), ov[s], lat[s]);
        end
        snap_r = ores[s];
        snap_f = {oc[s], oo[s], oz[s], on[s]};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            checks++;
            if (ir[s] !== 1'b0 || ov[s] !== 1'b1 || ores[s] !== snap_r ||
                {oc[s], oo[s], oz[s], on[s]} !== snap_f) begin
                errors++;
                $display("FAIL bp_hold dut%0d cyc%0d: in_ready=%b valid=%b result=%h, required 0/1/%h",
                         s, i, ir[s], ov[s], ores[s], snap_r);
            end
        end
        iv[s] = 1'b0;
        ordy[s] = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 40) begin
            #1;
            if (ov[s] === 1'b1) begin
                e = q.pop_front();
                checks++;
                if (ores[s] !== e.r || {oc[s], oo[s], oz[s], on[s]} !== {e.c, e.v, e.z, e.n}) begin
                    errors++;
                    $display("FAIL bp_drain dut%0d: result=%h cvzn=%b%b%b%b, required %h cvzn=%b%b%b%b",
                             s, ores[s], oc[s], oo[s], oz[s], on[s], e.r, e.c, e.v, e.z, e.n);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL bp_lost dut%0d: %0d beats never emitted, required 0", s, q.size());
        end
    endtask

    task automatic test_reset_midstream();
        int seen;
        seen = 0;
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; ia[0] = $urandom; ib[0] = $urandom; iop[0] = 1'b0; icin[0] = 1'b0;
            #1;
            checks++;
            if (ir[0] !== 1'b1) begin
                errors++;
                $display("FAIL rst_fill beat%0d: in_ready=%b, required 1", i, ir[0]);
            end
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || ores[0] !== 32'd0) begin
            errors++;
            $display("FAIL rst_flush: out_valid=%b result=%h, required 0/0", ov[0], ores[0]);
        end
        repeat (12) begin
            if (ov[0] === 1'b1) seen++;
            @(posedge clk); #2;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_ghost: %0d discarded beats emitted, required 0", seen);
        end
    endtask

    initial begin
        rst  = 1'b1;
        iv   = '0; iop = '0; icin = '0; ordy = '1;
        ia   = '0; ib  = '0;
        test_reset();
        for (int s = 0; s < 3; s++) begin
            test_directed(s);
            test_back_to_back(s, 16, 1'b0);
        end
        test_back_to_back(3, 1024, 1'b1);
        test_backpressure(0);
        test_backpressure(2);
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
